// File: rtl/bk_multiword_seq_if.sv
// rtl/bk_multiword_seq_if.sv - operand/result handshake bundle for bk_multiword_seq
// The in_sub signal exists only when BKSEQ_SUB_EN is defined.
interface bk_multiword_seq_if #(
    parameter int BITS  = 64,
    parameter int WORDS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WORDS*BITS-1:0]  in_a;
    logic [WORDS*BITS-1:0]  in_b;
    logic                   in_cin;
`ifdef BKSEQ_SUB_EN
    logic                   in_sub;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [WORDS*BITS-1:0]  out_sum;
    logic                   out_cout;
    logic                   out_ovf;

`ifdef BKSEQ_SUB_EN
    modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                    input  in_ready, out_valid, out_sum, out_cout, out_ovf);
    modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                    output in_ready, out_valid, out_sum, out_cout, out_ovf);
`else
    modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                    input  in_ready, out_valid, out_sum, out_cout, out_ovf);
    modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                    output in_ready, out_valid, out_sum, out_cout, out_ovf);
`endif
endinterface

// File: rtl/bk_multiword_seq.sv
// rtl/bk_multiword_seq.sv - multi-word add sequencer around one Brent_Kung adder
// Optional subtract mode is enabled by defining BKSEQ_SUB_EN.
module Brent_Kung #(
    parameter int bits = 64
) (
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic            cin,
    output logic [bits-1:0] sum,
    output logic            cout
);
    logic [bits-1:0] p_bit;
    logic [bits-1:0] gg;
    logic [bits-1:0] pp;

    // Carry-in is folded into bit 0 so gg[i] becomes the carry out of bit i.
    always_comb begin
        p_bit = a ^ b;
        gg    = a & b;
        pp    = p_bit;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int d = 1; d < bits; d = d * 2) begin
            for (int i = 2 * d - 1; i < bits; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = bits / 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < bits; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        sum[0] = p_bit[0] ^ cin;
        for (int i = 1; i < bits; i++) begin
            sum[i] = p_bit[i] ^ gg[i-1];
        end
        cout = gg[bits-1];
    end
endmodule

module bk_multiword_seq #(
    parameter int BITS  = 64,
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bk_multiword_seq_if.slave bus
);
    localparam int              IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WORDS*BITS-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic                   sub_q, sub_in;
    logic [BITS-1:0]        a_word, b_word, add_sum;
    logic                   add_cout;

`ifdef BKSEQ_SUB_EN
    assign sub_in = bus.in_sub;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid) begin
            sub_q <= bus.in_sub;
        end
    end
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    // The carry register is the only path between successive words.
    assign a_word = a_q[int'(idx_q)*BITS +: BITS];
    assign b_word = sub_q ? ~b_q[int'(idx_q)*BITS +: BITS] : b_q[int'(idx_q)*BITS +: BITS];

    Brent_Kung #(.bits(BITS)) u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)      state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (bus.out_ready)     state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && bus.in_valid) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            carry_d = sub_in ? 1'b1 : bus.in_cin;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == RUN) begin
            sum_d[int'(idx_q)*BITS +: BITS] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
                cout_d = add_cout;
                ovf_d  = (a_word[BITS-1] == b_word[BITS-1]) &&
                         (add_sum[BITS-1] != a_word[BITS-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_sum  = sum_q;
    assign bus.out_cout = cout_q;
    assign bus.out_ovf  = ovf_q;
endmodule

// File: tb/tb_bk_multiword_seq.sv
// tb/tb_bk_multiword_seq.sv - directed checks of bk_multiword_seq, BITS=8 WORDS=4
// Subtract cases run only when BKSEQ_SUB_EN is defined.
module tb_bk_multiword_seq;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bk_multiword_seq_if #(.BITS(8), .WORDS(4)) bus ();

    bk_multiword_seq #(.BITS(8), .WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          output logic [31:0] s, output logic co, output logic ov,
                          output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s  = bus.out_sum;
        co = bus.out_cout;
        ov = bus.out_ovf;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0 ||
            bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b sum=%h co=%b ov=%b, need 1 0 00000000 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b, need 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_carry_words();
        logic [31:0] s; logic co, ov; int lat;
        run_op(32'h00FFFFFF, 32'h00000001, 1'b0, s, co, ov, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL carry_latency: got %0d cycles, need 4", lat);
        end
        n_tests++;
        if (s !== 32'h01000000 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_words: sum=%h co=%b ov=%b, need 01000000 0 0", s, co, ov);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_handshake: rdy=%b vld=%b, need 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] s; logic co, ov; int lat;
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, s, co, ov, lat);
        n_tests++;
        if (lat !== 4 || s !== 32'h00000000 || co !== 1'b1 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wrap: lat=%0d sum=%h co=%b ov=%b, need 4 00000000 1 0", lat, s, co, ov);
        end
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, s, co, ov, lat);
        n_tests++;
        if (lat !== 4 || s !== 32'h80000000 || co !== 1'b0 || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL signed_ovf: lat=%0d sum=%h co=%b ov=%b, need 4 80000000 0 1", lat, s, co, ov);
        end
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, s, co, ov, lat);
        n_tests++;
        if (s !== 32'hACF13568 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_add: sum=%h co=%b ov=%b, need acf13568 0 0", s, co, ov);
        end
    endtask

    task automatic test_cin();
        logic [31:0] s; logic co, ov; int lat;
        run_op(32'h00000000, 32'h00000000, 1'b1, s, co, ov, lat);
        n_tests++;
        if (lat !== 4 || s !== 32'h00000001 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_in: lat=%0d sum=%h co=%b ov=%b, need 4 00000001 0 0", lat, s, co, ov);
        end
        run_op(32'h80FF00FF, 32'h80000000, 1'b1, s, co, ov, lat);
        n_tests++;
        if (s !== 32'h00FF0100 || co !== 1'b1 || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_in_ovf: sum=%h co=%b ov=%b, need 00ff0100 1 1", s, co, ov);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s; logic co, ov; int lat;
        bus.in_a     = 32'h00000010;
        bus.in_b     = 32'h00000020;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles, need 4", lat);
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_a     = 32'h11111111;
            bus.in_b     = 32'h22222222;
            bus.in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'h00000030 ||
                bus.out_cout !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%b sum=%h co=%b rdy=%b, need 1 00000030 0 0",
                         i, bus.out_valid, bus.out_sum, bus.out_cout, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== 32'h00000030) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b sum=%h, need 1 0 00000030",
                     bus.in_ready, bus.out_valid, bus.out_sum);
        end
        run_op(32'h11111111, 32'h22222222, 1'b0, s, co, ov, lat);
        n_tests++;
        if (lat !== 4 || s !== 32'h33333333 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_op: lat=%0d sum=%h co=%b ov=%b, need 4 33333333 0 0", lat, s, co, ov);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s; logic co, ov; int lat;
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, s, co, ov, lat);
        bus.in_a     = 32'h01010101;
        bus.in_b     = 32'h01010101;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_sum !== 32'h00000202) begin
            n_fail++;
            $display("FAIL mid_run_partial: sum=%h, need 00000202", bus.out_sum);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0 || bus.out_cout !== 1'b0 ||
            bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_reset: vld=%b sum=%h co=%b ov=%b rdy=%b, need 0 00000000 0 0 1",
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, bus.in_ready);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_release: rdy=%b vld=%b, need 1 0", bus.in_ready, bus.out_valid);
        end
        run_op(32'h00000003, 32'h00000004, 1'b0, s, co, ov, lat);
        n_tests++;
        if (lat !== 4 || s !== 32'h00000007 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op: lat=%0d sum=%h co=%b ov=%b, need 4 00000007 0 0", lat, s, co, ov);
        end
    endtask

`ifdef BKSEQ_SUB_EN
    task automatic test_sub();
        logic [31:0] s; logic co, ov; int lat;
        bus.in_sub = 1'b1;
        run_op(32'h00000005, 32'h00000007, 1'b1, s, co, ov, lat);
        n_tests++;
        if (lat !== 4 || s !== 32'hFFFFFFFE || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: lat=%0d sum=%h co=%b ov=%b, need 4 fffffffe 0 0", lat, s, co, ov);
        end
        run_op(32'h80000000, 32'h00000001, 1'b0, s, co, ov, lat);
        n_tests++;
        if (lat !== 4 || s !== 32'h7FFFFFFF || co !== 1'b1 || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_ovf: lat=%0d sum=%h co=%b ov=%b, need 4 7fffffff 1 1", lat, s, co, ov);
        end
        bus.in_sub = 1'b0;
        run_op(32'h00000005, 32'h00000007, 1'b0, s, co, ov, lat);
        n_tests++;
        if (s !== 32'h0000000C || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_off_add: sum=%h co=%b ov=%b, need 0000000c 0 0", s, co, ov);
        end
    endtask
`endif

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
`ifdef BKSEQ_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        test_reset();
        test_carry_words();
        test_wrap();
        test_cin();
        test_backpressure();
        test_reset_mid_run();
`ifdef BKSEQ_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bk_multiword_seq.md
# bk_multiword_seq

Multi-word add sequencer built around one shared `Brent_Kung` adder instance of width `BITS`. It accepts a wide operand pair of `WORDS*BITS` bits over a valid/ready handshake. It feeds the pair through the adder one `BITS`-wide word per cycle, least-significant word first, with the carry registered between words. It returns the full-width sum, carry-out and signed overflow over a second valid/ready handshake. It sits between an operand source and a result sink wherever the datapath needs sums wider than one adder instance.

## Interface
- `BITS`, 64: adder word width; power of two, ≥ 4; passed to `Brent_Kung` as `bits`.
- `WORDS`, 4: number of words per operand; ≥ 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low. All state clears immediately on assertion.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block accepts an operand pair this cycle.
- `in_a` input `WORDS*BITS`: operand A; word k is bits `[k*BITS +: BITS]`.
- `in_b` input `WORDS*BITS`: operand B, same layout as `in_a`.
- `in_cin` input 1: initial carry-in.
- `in_sub` input 1: subtract select; present only with `BKSEQ_SUB_EN`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: sink accepts the result.
- `out_sum` output `WORDS*BITS`: registered sum.
- `out_cout` output 1: carry out of the top word.
- `out_ovf` output 1: two's-complement overflow of the full-width operation.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`=1 at a rising edge:
    - latch `in_a`, `in_b` and `in_sub` into operand registers;
    - set the carry register to `in_cin` (to 1 when subtracting);
    - clear the word index `idx` to 0 and clear `out_sum`;
    - move to RUN.
- **RUN**
  - Adder inputs: A word `idx`, effective B word `idx` (B, or ~B when subtracting), Cin = carry register.
  - Each edge:
    - write the adder SUM into `out_sum` word `idx`;
    - load the carry register with the adder Cout;
    - increment `idx`.
  - On the edge where `idx`=WORDS-1, move to DONE instead of incrementing. On that edge:
    - `out_cout` is loaded with Cout;
    - `out_ovf` is loaded with (A_msb == Beff_msb) && (SUM_msb != A_msb), where the msbs are those of the top word.
- **DONE**
  - `out_valid`=1.
  - `out_sum`, `out_cout` and `out_ovf` are held stable.
  - When `out_ready`=1 at an edge, move to IDLE. `out_sum`, `out_cout` and `out_ovf` keep their values until the next acceptance.
- `in_ready`=0 in RUN and DONE. `in_valid` is ignored in those states and the operand registers are unaffected.
- `out_valid`=0 in IDLE and RUN.
- `in_ready` and `out_valid` are decoded purely from state. There is no combinational path from input to output.
- Arithmetic is modulo 2^(WORDS*BITS). The operands are not modified after acceptance.
- WORDS=1: RUN lasts exactly one cycle.
- Reset mid-operation: the FSM returns to IDLE and all of the following are zero: `out_valid`, `out_sum`, `out_cout`, `out_ovf`, `idx`, carry register. The partial result is discarded. `in_ready`=1 from reset release.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0.
- Acceptance at edge E0. RUN occupies the cycles after edges E0 through E(WORDS-1). `out_valid` rises after edge E(WORDS), i.e. latency is WORDS cycles.
- Result handshake completes at the first edge with `out_ready`=1 while in DONE. `in_ready` is high in the following cycle.
- Best-case throughput: one operation per WORDS+2 cycles.
- Adder path: the operand register mux feeds the combinational `Brent_Kung`, which feeds the `out_sum` word register, all within one cycle. The carry register is the only inter-word path.

## Configuration
- `BKSEQ_SUB_EN` defined:
  - port `in_sub` exists and is latched on acceptance.
  - `in_sub`=1: effective B = ~B for every word, initial carry = 1 and `in_cin` is ignored. `out_cout` = NOT borrow. `out_ovf` uses the inverted B msb.
  - `in_sub`=0: pure addition.
- `BKSEQ_SUB_EN` not defined: no `in_sub` port, effective B = B, initial carry = `in_cin`. The block performs addition only.

## Test plan
Benches use BITS=8, WORDS=4; values are 32-bit hex.
- Carry across words: A=00FFFFFF, B=00000001, cin=0 -> `out_sum`=01000000, cout=0, ovf=0; `out_valid` is high 4 cycles after acceptance.
- Full wrap: A=FFFFFFFF, B=00000001 -> sum=00000000, cout=1, ovf=0. Separately, A=7FFFFFFF, B=00000001 -> sum=80000000, cout=0, ovf=1.
- Carry-in: A=00000000, B=00000000, cin=1 -> sum=00000001, cout=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while pulsing `in_valid` with new operands -> `out_valid`, sum and cout remain stable and `in_ready`=0. After `out_ready`=1, `in_ready`=1 next cycle and the new operands are then accepted.
- Reset mid-RUN: assert `rst_n`=0 at idx=2 -> `out_valid`, `out_sum`, `out_cout` and `out_ovf` are 0 immediately and `in_ready`=1 after release. The next operation, A=00000003 and B=00000004, gives sum=00000007.
- With `BKSEQ_SUB_EN`:
  - in_sub=1, A=00000005, B=00000007 -> sum=FFFFFFFE, cout=0, ovf=0.
  - in_sub=1, A=80000000, B=00000001 -> sum=7FFFFFFF, cout=1, ovf=1.
